// File: rtl/reg0_uart_tx.sv
// reg0_uart_tx: FIFO-buffered 8N1 UART transmitter for bytes the core stores to reg0
module reg0_uart_tx #(
  parameter int CLK_DIV = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       rst,
  input  logic       clk,
  input  logic [7:0] reg0,
  input  logic       reg0_wr,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       overflow
);
  localparam int TW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TW-1:0] RELOAD = TW'(CLK_DIV - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;
  logic [2:0] idx;
  logic [7:0] shift;
  logic push, pop, nonempty;
  assign nonempty = count != '0;
  assign full = count == CW'(FIFO_DEPTH);
  assign busy = (state != IDLE) | nonempty;
  assign push = reg0_wr & ~full;
  assign pop = nonempty & ((state == IDLE) | ((state == STOP) & (timer == '0)));
  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk)
    if (push) mem[wptr] <= reg0;
  // FIFO bookkeeping and the transmit state machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      state <= IDLE;
      timer <= '0;
      idx <= '0;
      shift <= '0;
      tx <= 1'b1;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (reg0_wr & full) overflow <= 1'b1;
      case (state)
        IDLE: begin
          tx <= ~nonempty;
          if (nonempty) begin
            shift <= mem[rptr];
            timer <= RELOAD;
            state <= START;
          end
        end
        START: begin
          timer <= (timer == '0) ? RELOAD : timer - 1'b1;
          if (timer == '0) begin
            tx <= shift[0];
            idx <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          timer <= (timer == '0) ? RELOAD : timer - 1'b1;
          if (timer == '0) begin
            if (idx != 3'd7) begin
              shift <= shift >> 1;
              tx <= shift[1];
              idx <= idx + 1'b1;
            end else begin
              tx <= 1'b1;
              state <= STOP;
            end
          end
        end
        default: begin
          timer <= (timer == '0) ? RELOAD : timer - 1'b1;
          if (timer == '0) begin
            if (nonempty) begin
              shift <= mem[rptr];
              tx <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reg0_uart_tx.sv
// tb_reg0_uart_tx: directed self-checking bench for reg0_uart_tx with CLK_DIV=4, FIFO_DEPTH=4
module tb_reg0_uart_tx;
  localparam int D = 4;
  logic rst, clk, reg0_wr, run;
  logic [7:0] reg0;
  logic tx, busy, full, overflow;
  int cmp = 0;
  int errs = 0;

  reg0_uart_tx #(.CLK_DIV(D), .FIFO_DEPTH(4)) dut (
    .rst(rst), .clk(clk), .reg0(reg0), .reg0_wr(reg0_wr),
    .tx(tx), .busy(busy), .full(full), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = run ? ~clk : clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    cmp++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_start;
    int n = 0;
    while (tx !== 1'b0 && n < 200) begin
      tick;
      n++;
    end
    chk("start_timeout", 8'(n < 200), 8'd1);
  endtask

  // checks tx and busy every clock of a frame, beginning at frame cycle 'first'
  task automatic check_frame(input logic [7:0] b, input int first);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int k = first; k < 10 * D; k++) begin
      chk($sformatf("frame_%h_c%0d", b, k), {6'd0, busy, tx}, {6'd0, 1'b1, f[k / D]});
      tick;
    end
  endtask

  task automatic wr_byte(input logic [7:0] b);
    reg0 = b;
    reg0_wr = 1'b1;
    tick;
    reg0_wr = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    run = 1'b0;
    rst = 1'b0;
    reg0 = '0;
    reg0_wr = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_tx", 8'(tx), 8'd1);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_full", 8'(full), 8'd0);
    chk("rst_ovf", 8'(overflow), 8'd0);
    run = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tick;
    // single byte
    wr_byte(8'hA5);
    chk("single_tx_before_pop", 8'(tx), 8'd1);
    chk("single_busy_queued", 8'(busy), 8'd1);
    tick;
    chk("single_tx_fall", 8'(tx), 8'd0);
    check_frame(8'hA5, 0);
    chk("single_busy_end", 8'(busy), 8'd0);
    chk("single_tx_idle", 8'(tx), 8'd1);
    tick;
    tick;
    // back-to-back frames
    reg0 = 8'h01;
    reg0_wr = 1'b1;
    tick;
    reg0 = 8'h80;
    tick;
    reg0 = 8'hFF;
    tick;
    reg0_wr = 1'b0;
    check_frame(8'h01, 1);
    check_frame(8'h80, 0);
    check_frame(8'hFF, 0);
    chk("b2b_busy_end", 8'(busy), 8'd0);
    chk("b2b_ovf", 8'(overflow), 8'd0);
    tick;
    // overflow: six consecutive strobes, the last one dropped
    reg0_wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      reg0 = 8'h10 + 8'(i);
      tick;
      chk($sformatf("ovf_full_%0d", i), 8'(full), 8'(i >= 4));
      chk($sformatf("ovf_flag_%0d", i), 8'(overflow), 8'(i == 5));
    end
    reg0_wr = 1'b0;
    check_frame(8'h10, 4);
    for (int i = 1; i < 5; i++) check_frame(8'h10 + 8'(i), 0);
    chk("ovf_busy_end", 8'(busy), 8'd0);
    chk("ovf_tx_idle", 8'(tx), 8'd1);
    for (int i = 0; i < 10; i++) tick;
    chk("ovf_sticky", 8'(overflow), 8'd1);
    // pointer wrap: nine frames spaced apart
    for (int i = 0; i < 9; i++) begin
      b = 8'(i * 37) ^ 8'h5A;
      wr_byte(b);
      chk($sformatf("wrap_full_%0d", i), 8'(full), 8'd0);
      wait_start;
      check_frame(b, 0);
      chk($sformatf("wrap_busy_%0d", i), 8'(busy), 8'd0);
    end
    chk("wrap_ovf_sticky", 8'(overflow), 8'd1);
    // reset during data bit 3 with two bytes queued
    reg0 = 8'hF0;
    reg0_wr = 1'b1;
    tick;
    reg0 = 8'h3C;
    tick;
    reg0_wr = 1'b0;
    chk("mid_start", 8'(tx), 8'd0);
    for (int i = 0; i < 18; i++) tick;
    chk("mid_bit3_low", 8'(tx), 8'd0);
    chk("mid_busy", 8'(busy), 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx", 8'(tx), 8'd1);
    chk("mid_rst_busy", 8'(busy), 8'd0);
    chk("mid_rst_full", 8'(full), 8'd0);
    chk("mid_rst_ovf", 8'(overflow), 8'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick;
      chk($sformatf("post_rst_%0d", i), {6'd0, busy, tx}, 8'b01);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
